// File: rtl/uart_rx_core_if.sv
// ---------------------------------------------------------------------------
// uart_rx_core_if
// Bundles the receiver's line input and its outputs toward the operand/opcode
// sequencer.
//   rx        : serial line, idle high (driven by the line side)
//   dout      : last received data word
//   rx_done   : one-cycle strobe, valid frame received, dout updated
//   frame_err : one-cycle strobe, stop bit sampled low
//   busy      : frame in progress
//   tick      : shared 16x baud tick
// Modports: slave = receiver core, master = line/sequencer side.
// ---------------------------------------------------------------------------
interface uart_rx_core_if #(
    parameter int DBIT = 8
) ();
    logic            rx;
    logic [DBIT-1:0] dout;
    logic            rx_done;
    logic            frame_err;
    logic            busy;
    logic            tick;

    modport slave (
        input  rx,
        output dout, rx_done, frame_err, busy, tick
    );

    modport master (
        output rx,
        input  dout, rx_done, frame_err, busy, tick
    );
endinterface

// File: rtl/uart_rx_core.sv
// ---------------------------------------------------------------------------
// uart_rx_core
// 16x oversampling 8N1 UART receiver, LSB first. Delivers each byte with a
// one-cycle rx_done strobe, flags a low stop bit with frame_err, and exports
// the free-running 16x baud tick.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : uart_rx_core_if.slave (rx in; dout, rx_done, frame_err, busy,
//           tick out)
// ---------------------------------------------------------------------------
module uart_rx_core #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600,
    parameter int DBIT     = 8,
    parameter int DIV      = (CLK_FREQ + BAUD * 8) / (BAUD * 16)
) (
    input  logic           clk,
    input  logic           reset,
    uart_rx_core_if.slave  bus
);

    localparam int DIV_EFF = (DIV < 1) ? 1 : DIV;
    localparam int DCW     = (DIV_EFF > 1) ? $clog2(DIV_EFF) : 1;
    localparam int NW      = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV_EFF - 1);
    localparam logic [NW-1:0]  N_LAST   = NW'(DBIT - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BREAK = 3'd4;

    logic [DCW-1:0]  r_div;
    logic            r_tick;
    logic            r_sync1;
    logic            r_sync2;
    logic [2:0]      r_state;
    logic [3:0]      r_s;
    logic [NW-1:0]   r_n;
    logic [DBIT-1:0] r_shift;
    logic [DBIT-1:0] r_dout;
    logic            r_done;
    logic            r_ferr;

    logic            w_rxs;
    logic            w_sample_data;

    assign w_rxs         = r_sync2;
    assign w_sample_data = (r_state == DATA) && r_tick && (r_s == 4'd15);

    // Tick generator: free-running, independent of the frame state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else if (r_div == DIV_LAST) begin
            r_div  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_div  <= r_div + 1'b1;
            r_tick <= 1'b0;
        end
    end

    // Two-flop synchroniser, preset to the idle (high) line level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.rx;
            r_sync2 <= r_sync1;
        end
    end

    // Data shift register: new bit enters at the MSB so the first (LSB)
    // bit ends up in bit 0 after DBIT samples. Contents are irrelevant
    // until a full frame is shifted in, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_sample_data) begin
            r_shift <= {w_rxs, r_shift[DBIT-1:1]};
        end
    end

    // Frame FSM. Bits are sampled once per bit at s==15, which after the
    // s==7 start check lands in the middle of each bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_s     <= 4'd0;
            r_n     <= '0;
            r_dout  <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_ferr <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_rxs) begin
                        r_state <= START;
                        r_s     <= 4'd0;
                    end
                end
                START: begin
                    if (r_tick) begin
                        if (r_s == 4'd7) begin
                            r_s <= 4'd0;
                            r_n <= '0;
                            // A start that is high again at mid-bit is a glitch.
                            r_state <= w_rxs ? IDLE : DATA;
                        end else begin
                            r_s <= r_s + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (r_tick) begin
                        if (r_s == 4'd15) begin
                            r_s <= 4'd0;
                            if (r_n == N_LAST) begin
                                r_state <= STOP;
                            end else begin
                                r_n <= r_n + 1'b1;
                            end
                        end else begin
                            r_s <= r_s + 4'd1;
                        end
                    end
                end
                STOP: begin
                    if (r_tick) begin
                        if (r_s == 4'd15) begin
                            r_s    <= 4'd0;
                            r_dout <= r_shift;
                            // Leaving at mid-stop-bit lets a back-to-back
                            // start bit be caught on its falling edge.
                            if (w_rxs) begin
                                r_done  <= 1'b1;
                                r_state <= IDLE;
                            end else begin
                                r_ferr  <= 1'b1;
                                r_state <= BREAK;
                            end
                        end else begin
                            r_s <= r_s + 4'd1;
                        end
                    end
                end
                BREAK: begin
                    // Hold off until the line recovers so a long low is not
                    // decoded as a stream of start bits.
                    if (w_rxs) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.dout      = r_dout;
    assign bus.rx_done   = r_done;
    assign bus.frame_err = r_ferr;
    assign bus.busy      = (r_state != IDLE);
    assign bus.tick      = r_tick;

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Serial receiver front end of the calculator UART path. It oversamples the `rx` pin at 16x baud and de-serialises 8N1 frames, LSB first. It delivers each byte with a one-cycle `rx_done` strobe to the operand/opcode sequencer that feeds the ALU. It also exports the 16x baud tick that the sequencer and transmitter share, and flags framing errors and line breaks.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz.
BAUD, 9600, line rate in bit/s.
DBIT, 8, data bits per frame.
DIV, (CLK_FREQ + BAUD*8)/(BAUD*16), clocks per 16x tick (integer, rounded to nearest; minimum 1).

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset).
rx  input  1  serial line, idle high, asynchronous to clk.
dout  output  DBIT  last received data word.
rx_done  output  1  one-cycle pulse: valid frame received, dout updated this cycle.
frame_err  output  1  one-cycle pulse: stop bit sampled low.
busy  output  1  high while a frame is in progress (states START/DATA/STOP/BREAK).
tick  output  1  one-cycle pulse every DIV clocks (16x baud).

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, all counters=0, dout=0, rx_done=0, frame_err=0, busy=0, tick=0, synchroniser flops=1.
- rx passes through a 2-flop synchroniser preset to 1; all decisions use the synchronised value rxs.
- Tick generator: free-running counter 0..DIV-1; tick=1 for the one cycle the counter wraps. It runs in every state and never stops outside reset.
- Counters: s (4-bit sample counter, 0..15) and n (bit index, 0..DBIT-1). Both advance only on tick cycles. Shift register: DBIT bits, right-shift, new bit enters at MSB.
- IDLE: when rxs=0 -> START, s=0. No tick qualification, so detection latency is 3 clk from the pin.
- START: on tick, if s==7, check rxs. If rxs=0 -> DATA, s=0, n=0. If rxs=1 (glitch) -> IDLE. Otherwise s++.
- DATA: on tick, if s==15, shift rxs in and set s=0. If n==DBIT-1 -> STOP, else n++. Otherwise s++.
- STOP: on tick, if s==15, check rxs:
  - rxs=1: dout<=shift register, rx_done=1 for 1 clk -> IDLE.
  - rxs=0: dout<=shift register, frame_err=1 for 1 clk -> BREAK.
  - Otherwise s++.
- BREAK: stay until rxs=1, then -> IDLE. A held-low line must not be decoded as further start bits.
- rx_done and frame_err are registered and never asserted together. dout is stable between strobes.
- STOP returns to IDLE at mid-stop-bit, so back-to-back frames with zero idle time are received.
- Latency: with DIV exact, rx_done asserts about 9.5 bit times (DBIT+1.5 bits) after the pin falling edge. Tolerance is +2 sync clk +1 tick.
- Start alignment error is at most 1 tick (1/16 bit). No resynchronisation mid-frame.
- Reset mid-frame: frame is discarded, with no rx_done or frame_err. After release, a low rx is treated as a new start only after it is synchronised.
- rx toggling during DATA between sample points is ignored. Only the s==15 sample counts, with no majority vote.

Test Plan:
Use CLK_FREQ=16_000_000 and BAUD=250_000 (DIV=4, 64 clk/bit) for all scenarios.
1. Tick: after reset release, tick pulses exactly every 4 clk, 1 clk wide. busy=0, dout=0.
2. Send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> single rx_done pulse about 608 clk (+0..6) after the falling edge. dout=8'hA5, frame_err=0, busy low afterwards.
3. Glitch: rx low for 16 clk, then high -> no rx_done/frame_err. busy returns to 0 within 40 clk.
4. 0x3C frame with a low stop bit, rx then held low 3 bit times before going high -> one frame_err pulse, dout=8'h3C, no rx_done, no extra frames during the low period. A following 0x0F frame gives rx_done with dout=8'h0F.
5. Back-to-back 0x00 then 0xFF, with the next start immediately after the stop bit -> two rx_done pulses, dout=8'h00 then 8'hFF, no frame_err.
6. Reset asserted mid-DATA of frame 0x77 -> outputs go to 0 immediately, no strobe. After release with rx=1, a 0x5A frame gives rx_done with dout=8'h5A.
